game_state_core: RTL
====================

GAME_STATE_CORE -- requirements
Module: game_state_core

Interface
REQ-001 Parameter CLK_HZ, 1000000, clk_1mhz cycles per one-second tick.
REQ-002 Parameter READY_SEC, 3, countdown seconds loaded on entering ready.
REQ-003 Parameter PLAY_SEC, 30, play seconds loaded on entering playing.
REQ-004 Ports:
- clk_1mhz in 1: sole clock.
- rst in 1: reset.
- flag in 4: command code.
- trig in 1: command strobe.
- done out 1: command acknowledge.
- sec_posedge out 1: one-cycle pulse per timer decrement.
- timer_running out 1: countdown active.
- timer out 7: seconds remaining.
- state out 3: 1 ready, 2 playing, 3 game over, 4 stage clear, 5 game clear.
- stage out 2: current stage, 1..3.
- lives out 2: remaining lives.
- score out 10: hits.
REQ-005 Single clock clk_1mhz; rst is synchronous and active-high.

Function
REQ-006 Command executes only on the trig rising edge (trig=1, previous sample 0); flag is sampled in that same cycle.
REQ-007 done=1 the cycle after an executed command, stays 1 while trig=1, and clears in the first cycle trig=0.
REQ-008 Command codes:
- 0001: score+1, playing only.
- 0010: lives-1, playing only.
- 0101: start countdown, ready only.
- 1010: ready->playing.
- 1100: playing->stage clear.
- 1110: playing->game clear.
- 1101: playing->game over.
- 1000: states 3/4/5->ready.
REQ-009 Any other code, or any code outside its listed state, has no effect except done.
REQ-010 Entering ready: timer=READY_SEC, timer_running=0.
REQ-011 Entering playing: timer=PLAY_SEC, timer_running=1.
REQ-012 Entering states 3/4/5: timer_running=0; timer holds its value.
REQ-013 0101: timer_running=1 if timer!=0; ignored if timer=0.
REQ-014 Prescaler clears on every timer load or start; while running, a tick occurs every CLK_HZ cycles.
REQ-015 On each tick: timer-1, sec_posedge=1 for that single cycle; if the new timer=0, timer_running=0 in the same cycle.
REQ-016 Stage clear->ready: stage+1; lives and score retained.
REQ-017 Game over->ready or game clear->ready: stage=1, lives=3, score=0.
REQ-018 Score saturates at 999; lives saturate at 0.
REQ-019 A command and a tick in the same cycle: a state-changing command overrides the tick (no decrement, no pulse). A score or lives command and the tick both apply.
REQ-020 State never changes without a command; no auto-transition on lives=0 or timer=0.

Reset
REQ-021 rst overrides any simultaneous trig.
REQ-022 Reset values: state=1, stage=1, lives=3, score=0, timer=READY_SEC, timer_running=0, done=0, sec_posedge=0, prescaler=0, trig history=0.
REQ-023 Reset mid-countdown: next cycle shows reset values and no tick pulse.

Configuration
REQ-024 Macro GAME_STATE_LIFE_BONUS_EN.
REQ-025 Defined: on 1100, score += 10*lives, saturating at 999.
REQ-026 Undefined: 1100 leaves score unchanged; no bonus logic synthesized.

Verification (CLK_HZ=10, READY_SEC=3, PLAY_SEC=5)
REQ-027 Reset, then 0101 pulse:
- timer_running=1.
- Three sec_posedge pulses 10 cycles apart, timer 2,1,0.
- timer_running falls on the third pulse.
REQ-028 1010 then five 0001 pulses:
- state=2, timer=5.
- score=5, done one cycle after each trig.
REQ-029 Playing with lives=3, four 0010 pulses:
- lives 2,1,0,0.
- Then 1101: state=3.
- Then 1000: state=1, lives=3, score=0, stage=1.
REQ-030 Stage 1 with score=7, lives=2, 1100 then 1000:
- With macro: score=27.
- Without macro: score=7.
- Then stage=2, state=1, timer=3.
REQ-031 Timing and level cases:
- trig held high 5 cycles with 0001: score+1 only, done high cycles 2-6.
- rst asserted with trig and mid-countdown: reset values next cycle.

Source files
------------

// File: rtl/game_state_core.sv
// Game state sequencer: command decoder, one-second countdown timer, stage/lives/score bookkeeping.
// Define GAME_STATE_LIFE_BONUS_EN to award 10 points per remaining life on stage clear.
module game_state_core #(
    parameter int CLK_HZ    = 1000000,
    parameter int READY_SEC = 3,
    parameter int PLAY_SEC  = 30
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic [3:0] flag,
    input  logic       trig,
    output logic       done,
    output logic       sec_posedge,
    output logic       timer_running,
    output logic [6:0] timer,
    output logic [2:0] state,
    output logic [1:0] stage,
    output logic [1:0] lives,
    output logic [9:0] score
);
    typedef enum logic [2:0] {
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3,
        ST_SCLR  = 3'd4,
        ST_GCLR  = 3'd5
    } state_t;

    localparam logic [3:0] CMD_SCORE = 4'b0001;
    localparam logic [3:0] CMD_LIFE  = 4'b0010;
    localparam logic [3:0] CMD_START = 4'b0101;
    localparam logic [3:0] CMD_PLAY  = 4'b1010;
    localparam logic [3:0] CMD_SCLR  = 4'b1100;
    localparam logic [3:0] CMD_GCLR  = 4'b1110;
    localparam logic [3:0] CMD_OVER  = 4'b1101;
    localparam logic [3:0] CMD_READY = 4'b1000;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [9:0] SCORE_MAX = 10'd999;

    state_t        state_reg, state_next;
    logic [1:0]    stage_reg, stage_next;
    logic [1:0]    lives_reg, lives_next;
    logic [9:0]    score_reg, score_next;
    logic [6:0]    timer_reg, timer_next;
    logic          running_reg, running_next;
    logic          done_reg, done_next;
    logic          pulse_reg, pulse_next;
    logic          trig_prev_reg, trig_prev_next;
    logic [PW-1:0] presc_reg, presc_next;

    logic cmd_fire;
    logic tick;
    logic tick_override;

    assign cmd_fire = trig & ~trig_prev_reg;
    assign tick     = running_reg && (presc_reg == PRESC_MAX);

`ifdef GAME_STATE_LIFE_BONUS_EN
    logic [10:0] bonus_sum;
    assign bonus_sum = {1'b0, score_reg} + (11'(lives_reg) * 11'd10);
`endif

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state_reg     <= ST_READY;
            stage_reg     <= 2'd1;
            lives_reg     <= 2'd3;
            score_reg     <= '0;
            timer_reg     <= 7'(READY_SEC);
            running_reg   <= 1'b0;
            done_reg      <= 1'b0;
            pulse_reg     <= 1'b0;
            trig_prev_reg <= 1'b0;
            presc_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            lives_reg     <= lives_next;
            score_reg     <= score_next;
            timer_reg     <= timer_next;
            running_reg   <= running_next;
            done_reg      <= done_next;
            pulse_reg     <= pulse_next;
            trig_prev_reg <= trig_prev_next;
            presc_reg     <= presc_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        stage_next     = stage_reg;
        lives_next     = lives_reg;
        score_next     = score_reg;
        timer_next     = timer_reg;
        running_next   = running_reg;
        pulse_next     = 1'b0;
        trig_prev_next = trig;
        done_next      = trig & (done_reg | cmd_fire);
        presc_next     = running_reg ? (tick ? '0 : presc_reg + 1'b1) : '0;
        tick_override  = 1'b0;

        // Timer loads/starts restart the prescaler and swallow a coincident tick.
        if (cmd_fire) begin
            case (flag)
                CMD_SCORE: if (state_reg == ST_PLAY)
                    score_next = (score_reg >= SCORE_MAX) ? SCORE_MAX : score_reg + 10'd1;
                CMD_LIFE: if (state_reg == ST_PLAY)
                    lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
                CMD_START: if (state_reg == ST_READY && timer_reg != 7'd0) begin
                    running_next  = 1'b1;
                    presc_next    = '0;
                    tick_override = 1'b1;
                end
                CMD_PLAY: if (state_reg == ST_READY) begin
                    state_next    = ST_PLAY;
                    timer_next    = 7'(PLAY_SEC);
                    running_next  = 1'b1;
                    presc_next    = '0;
                    tick_override = 1'b1;
                end
                CMD_SCLR: if (state_reg == ST_PLAY) begin
                    state_next    = ST_SCLR;
                    running_next  = 1'b0;
                    tick_override = 1'b1;
`ifdef GAME_STATE_LIFE_BONUS_EN
                    score_next = (bonus_sum > 11'(SCORE_MAX)) ? SCORE_MAX : bonus_sum[9:0];
`endif
                end
                CMD_GCLR: if (state_reg == ST_PLAY) begin
                    state_next    = ST_GCLR;
                    running_next  = 1'b0;
                    tick_override = 1'b1;
                end
                CMD_OVER: if (state_reg == ST_PLAY) begin
                    state_next    = ST_OVER;
                    running_next  = 1'b0;
                    tick_override = 1'b1;
                end
                CMD_READY: if (state_reg == ST_OVER || state_reg == ST_SCLR || state_reg == ST_GCLR) begin
                    if (state_reg == ST_SCLR) begin
                        stage_next = (stage_reg == 2'd3) ? 2'd3 : stage_reg + 2'd1;
                    end else begin
                        stage_next = 2'd1;
                        lives_next = 2'd3;
                        score_next = '0;
                    end
                    state_next    = ST_READY;
                    timer_next    = 7'(READY_SEC);
                    running_next  = 1'b0;
                    presc_next    = '0;
                    tick_override = 1'b1;
                end
                default: ;
            endcase
        end

        if (tick && !tick_override) begin
            timer_next = timer_reg - 7'd1;
            pulse_next = 1'b1;
            if (timer_reg == 7'd1) running_next = 1'b0;
        end
    end

    assign done          = done_reg;
    assign sec_posedge   = pulse_reg;
    assign timer_running = running_reg;
    assign timer         = timer_reg;
    assign state         = state_reg;
    assign stage         = stage_reg;
    assign lives         = lives_reg;
    assign score         = score_reg;
endmodule
